cp0_irq_timer: RTL

Parametrised MIPS coprocessor-0 for the pipelined CPU: holds SR, Cause, EPC, PrID, Count and Compare, arbitrates exceptions against a configurable number of external interrupt lines plus an internal interval timer, and produces the interrupt request and the handler return address. It sits beside the M stage. Exception code, PC and branch-delay flag arrive from M; `mfc0`/`mtc0` access uses `rreg`/`wreg`; `eret` drives `exl_clr`.

---
 rtl/cp0_pkg.sv | 22 ++
 rtl/cp0_count_timer.sv | 58 +++++
 rtl/cp0_irq_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// CP0 register indices, SR/Cause bit positions and the interrupt ExcCode shared by the CP0 block.
// Definitions only: no latency, no flow control.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/cp0_count_timer.sv
// Interval timer (built only with CP0_TIMER_EN): prescaled Count, Compare and the sticky TI match flag.
// Updates land one cycle after the edge that triggers them; never stalls.
`ifdef CP0_TIMER_EN
module cp0_count_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int            PW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] pre;
  logic          wrap;
  logic [31:0]   count_inc;

  assign wrap      = (pre == PRE_LAST);
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wd;
        pre   <= '0;
      end else if (wrap) begin
        count <= count_inc;
        pre   <= '0;
      end else begin
        pre <= pre + PW'(1);
      end

      if (compare_we)
        compare <= wd;

      // A Compare write beats a same-cycle match, so TI stays clear.
      if (compare_we)
        ti <= 1'b0;
      else if (!count_we && wrap && (count_inc == compare))
        ti <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cp0_irq_timer.sv
// MIPS CP0 beside the M stage: SR/Cause/EPC/PrID, exception vs interrupt arbitration; timer under CP0_TIMER_EN.
// int_req, epc and rd are combinational (zero latency); state updates next cycle; no backpressure.
module cp0_irq_timer
  import cp0_pkg::*;
#(
  parameter int          N_HWINT    = 5,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0207,
  parameter int          COUNT_DIV  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [4:0]         wreg,
  input  logic [31:0]        wd,
  input  logic [4:0]         rreg,
  output logic [31:0]        rd,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc,
  input  logic               bd,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic               exl_clr,
  output logic               int_req,
  output logic [31:0]        epc,
  output logic               timer_irq
);

  if (N_HWINT < 1 || N_HWINT > 5 || COUNT_DIV < 1) begin : g_bad_param
    $error("cp0_irq_timer: N_HWINT must be 1..5 and COUNT_DIV >= 1");
  end

  logic [31:0] sr_q;
  logic [31:0] epc_q;
  logic [31:0] cause;
  logic [31:0] count;
  logic [31:0] compare;
  logic        bd_q;
  logic [4:0]  exc_q;
  logic [5:0]  ip_q;
  logic [5:0]  ip_live;
  logic [5:0]  im;
  logic        ti;
  logic        exl;
  logic        ireq;
  logic        ereq;

  assign im  = sr_q[SR_IM_LO +: 6];
  assign exl = sr_q[SR_EXL];

  always_comb begin
    ip_live              = '0;
    ip_live[N_HWINT-1:0] = hw_int;
    ip_live[5]           = ti;
  end

  assign ireq    = (|(ip_live & im)) && sr_q[SR_IE] && !exl;
  assign ereq    = (exc_code != 5'd0) && !exl;
  assign int_req = ireq || ereq;
  assign epc     = int_req ? (bd ? (pc - 32'd4) : pc) : epc_q;

`ifdef CP0_TIMER_EN
  logic count_we;
  logic compare_we;

  // Writes are dropped on the cycle an exception or interrupt is taken.
  assign count_we   = we && !int_req && (wreg == REG_COUNT);
  assign compare_we = we && !int_req && (wreg == REG_COMPARE);

  cp0_count_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_count_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wd         (wd),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  assign timer_irq = ti && im[5];
`else
  assign count     = '0;
  assign compare   = '0;
  assign ti        = 1'b0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    cause                            = '0;
    cause[CAUSE_BD]                  = bd_q;
    cause[CAUSE_TI]                  = ti;
    cause[CAUSE_IP_LO +: 6]          = ip_q;
    cause[CAUSE_EXC_LO +: 5]         = exc_q;
  end

  always_comb begin
    rd = '0;
    case (rreg)
      REG_COUNT:   rd = count;
      REG_COMPARE: rd = compare;
      REG_SR:      rd = sr_q;
      REG_CAUSE:   rd = cause;
      REG_EPC:     rd = epc_q;
      REG_PRID:    rd = PRID_VALUE;
      default:     rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      epc_q <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      ip_q  <= '0;
    end else begin
      ip_q <= ip_live;
      if (int_req) begin
        exc_q        <= ireq ? EXC_INT : exc_code;
        bd_q         <= bd;
        epc_q        <= epc;
        sr_q[SR_EXL] <= 1'b1;
      end else begin
        if (we && wreg == REG_SR)
          sr_q <= wd;
        if (we && wreg == REG_EPC)
          epc_q <= wd;
        // eret wins over a same-cycle SR write for the EXL bit.
        if (exl_clr)
          sr_q[SR_EXL] <= 1'b0;
      end
    end
  end

endmodule
